tmds_channel_decoder: RTL and testbench

//  Receive-side counterpart of the HDMI transmit path: one TMDS channel.

---
 rtl/tmds_channel_decoder.sv | 180 ++++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: bitslip-based word alignment on control tokens, then 10b->8b decode.
// Optional slip_count output when TMDS_SLIP_CNT_EN is defined.
module tmds_channel_decoder #(
  parameter int CTRL_RUN      = 8,
  parameter int SEARCH_WINDOW = 4096,
  parameter int SLIP_WAIT_CYC = 16,
  parameter int LOSS_WINDOW   = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] word_in,
  input  logic       word_valid,
  output logic       bitslip,
  output logic       locked,
  output logic       out_valid,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] data
`ifdef TMDS_SLIP_CNT_EN
  ,
  output logic [7:0] slip_count
`endif
);

  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam int WW = $clog2(SEARCH_WINDOW + 1);
  localparam int SW = $clog2(SLIP_WAIT_CYC + 1);
  localparam int LW = $clog2(LOSS_WINDOW + 1);

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  state_t          state_r;
  logic [RW-1:0]   run_r;
  logic [WW-1:0]   win_r;
  logic [SW-1:0]   wait_r;
  logic [LW-1:0]   loss_r;
  logic            bitslip_r;
  logic            locked_r;
  logic            out_valid_r;
  logic            de_r;
  logic [1:0]      ctrl_r;
  logic [7:0]      data_r;
  logic [7:0]      slip_cnt_r;

  logic            tok_s;
  logic [1:0]      tok_ctrl_s;
  logic [7:0]      dec_s;
  logic [RW-1:0]   run_inc_s;
  logic [WW-1:0]   win_inc_s;
  logic [LW-1:0]   loss_inc_s;

  // Returns {hit, C1, C0} for the four control tokens.
  function automatic logic [2:0] token_lookup(input logic [9:0] w);
    logic [2:0] r;
    case (w)
      10'b1101010100: r = 3'b100;
      10'b0010101011: r = 3'b101;
      10'b0101010100: r = 3'b110;
      10'b1010101011: r = 3'b111;
      default:        r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    q = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  // Token classification, decoded byte and next counter values.
  always_comb begin
    {tok_s, tok_ctrl_s} = token_lookup(word_in);
    dec_s      = tmds_decode(word_in);
    run_inc_s  = run_r + RW'(1);
    win_inc_s  = win_r + WW'(1);
    loss_inc_s = loss_r + LW'(1);
  end

  // Alignment FSM, lock status and registered decode outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_SEARCH;
      run_r       <= '0;
      win_r       <= '0;
      wait_r      <= '0;
      loss_r      <= '0;
      bitslip_r   <= 1'b0;
      locked_r    <= 1'b0;
      out_valid_r <= 1'b0;
      de_r        <= 1'b0;
      ctrl_r      <= 2'b00;
      data_r      <= 8'h00;
      slip_cnt_r  <= 8'h00;
    end else begin
      bitslip_r   <= 1'b0;
      out_valid_r <= word_valid && (state_r == ST_LOCKED);
      case (state_r)
        ST_SEARCH: begin
          if (word_valid) begin
            win_r <= win_inc_s;
            run_r <= tok_s ? run_inc_s : RW'(0);
            // Lock takes priority over a window expiry on the same word.
            if (tok_s && (run_inc_s == RW'(CTRL_RUN))) begin
              state_r  <= ST_LOCKED;
              locked_r <= 1'b1;
              loss_r   <= '0;
              run_r    <= '0;
              win_r    <= '0;
            end else if (win_inc_s == WW'(SEARCH_WINDOW)) begin
              state_r   <= ST_SLIP_WAIT;
              bitslip_r <= 1'b1;
              wait_r    <= '0;
              run_r     <= '0;
              win_r     <= '0;
              if (slip_cnt_r != 8'hFF) begin
                slip_cnt_r <= slip_cnt_r + 8'd1;
              end
            end
          end
        end
        ST_SLIP_WAIT: begin
          if (wait_r == SW'(SLIP_WAIT_CYC - 1)) begin
            state_r <= ST_SEARCH;
            run_r   <= '0;
            win_r   <= '0;
          end else begin
            wait_r <= wait_r + SW'(1);
          end
        end
        ST_LOCKED: begin
          if (word_valid) begin
            loss_r <= tok_s ? LW'(0) : loss_inc_s;
            if (!tok_s && (loss_inc_s == LW'(LOSS_WINDOW))) begin
              state_r  <= ST_SEARCH;
              locked_r <= 1'b0;
              run_r    <= '0;
              win_r    <= '0;
            end
          end
        end
        default: begin
          state_r  <= ST_SEARCH;
          locked_r <= 1'b0;
          run_r    <= '0;
          win_r    <= '0;
        end
      endcase
      if (word_valid && (state_r == ST_LOCKED)) begin
        if (tok_s) begin
          de_r   <= 1'b0;
          ctrl_r <= tok_ctrl_s;
        end else begin
          de_r   <= 1'b1;
          data_r <= dec_s;
        end
      end
    end
  end

  assign bitslip   = bitslip_r;
  assign locked    = locked_r;
  assign out_valid = out_valid_r;
  assign de        = de_r;
  assign ctrl      = ctrl_r;
  assign data      = data_r;
`ifdef TMDS_SLIP_CNT_EN
  assign slip_count = slip_cnt_r;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: scoreboard on the decode path,
// directed checks on lock, slip, loss, boundary and reset behaviour.
module tb_tmds_channel_decoder;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;

  typedef struct packed {
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] word_in = 10'h000;
  logic       word_valid = 1'b0;
  logic       bitslip, locked, out_valid, de;
  logic [1:0] ctrl;
  logic [7:0] data;
`ifdef TMDS_SLIP_CNT_EN
  logic [7:0] slip_count;
`endif

  int   checks = 0;
  int   errors = 0;
  int   slips = 0;
  logic prev_slip = 1'b0;
  exp_t sb[$];
  logic       exp_lock = 1'b0;
  logic [1:0] exp_ctrl = 2'b00;
  logic [7:0] exp_data = 8'h00;

  tmds_channel_decoder #(
    .CTRL_RUN(8), .SEARCH_WINDOW(16), .SLIP_WAIT_CYC(16), .LOSS_WINDOW(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .bitslip(bitslip), .locked(locked), .out_valid(out_valid), .de(de),
    .ctrl(ctrl), .data(data)
`ifdef TMDS_SLIP_CNT_EN
    , .slip_count(slip_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic is_tok(input logic [9:0] w);
    return (w == TOK00) || (w == TOK01) || (w == TOK10) || (w == TOK11);
  endfunction

  function automatic logic [1:0] tok_val(input logic [9:0] w);
    if (w == TOK01) return 2'b01;
    if (w == TOK10) return 2'b10;
    if (w == TOK11) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] q, d;
    q = w[7:0] ^ {8{w[9]}};
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = q[i] ^ q[i-1] ^ ~w[8];
    return d;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    w = 10'($urandom_range(0, 1023));
    if (is_tok(w)) w = 10'h100;
    return w;
  endfunction

  // Scoreboard pop on out_valid and bitslip pulse monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out_valid: got de=%0b ctrl=%0h data=%02h, required no output", de, ctrl, data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({de, ctrl, data} !== e) begin
            errors++;
            $display("FAIL scoreboard: got de=%0b ctrl=%0h data=%02h, required de=%0b ctrl=%0h data=%02h",
                     de, ctrl, data, e.de, e.ctrl, e.data);
          end
        end
      end
      if (bitslip) begin
        slips++;
        checks++;
        if (prev_slip !== 1'b0) begin
          errors++;
          $display("FAIL bitslip_width: got 2+ cycle pulse, required 1 cycle");
        end
      end
      prev_slip = bitslip;
    end
  end

  task automatic send(input logic [9:0] w, input logic v);
    word_in = w;
    word_valid = v;
    if (v && exp_lock) begin
      exp_t e;
      if (is_tok(w)) exp_ctrl = tok_val(w);
      else exp_data = ref_decode(w);
      e.de = ~is_tok(w);
      e.ctrl = exp_ctrl;
      e.data = exp_data;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    word_valid = 1'b0;
  endtask

  task automatic clear_model();
    sb.delete();
    exp_lock = 1'b0;
    exp_ctrl = 2'b00;
    exp_data = 8'h00;
    prev_slip = 1'b0;
    slips = 0;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({bitslip, locked, out_valid, de, ctrl, data} !== 14'h0) begin
      errors++;
      $display("FAIL %s: got bs=%0b lk=%0b ov=%0b de=%0b ctrl=%0h data=%02h, required all 0",
               name, bitslip, locked, out_valid, de, ctrl, data);
    end
`ifdef TMDS_SLIP_CNT_EN
    checks++;
    if (slip_count !== 8'd0) begin
      errors++;
      $display("FAIL %s_slip_count: got %0d, required 0", name, slip_count);
    end
`endif
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b", name, got, req);
    end
  endtask

  task automatic check_drained(input string name);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d outputs missing, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    for (int i = 0; i < 7; i++) send(TOK00, 1'b1);
    check_bit("lock_after_7", locked, 1'b0);
    send(TOK00, 1'b1);
    check_bit("lock_after_8", locked, 1'b1);
    exp_lock = 1'b1;
    checks++;
    if (slips != 0) begin
      errors++;
      $display("FAIL lock_no_slip: got %0d slips, required 0", slips);
    end
  endtask

  task automatic test_decode();
    send(10'h100, 1'b1);
    send(10'h2FF, 1'b1);
    send(TOK11, 1'b1);
    send(TOK01, 1'b1);
    for (int i = 0; i < 6; i++) send(rand_data(), 1'b1);
    send(TOK10, 1'b1);
    send(10'h0F3, 1'b1);
    send(TOK00, 1'b0);
    check_bit("decode_gap_no_valid", out_valid, 1'b0);
    checks++;
    if ({de, ctrl, data} !== {1'b1, exp_ctrl, exp_data}) begin
      errors++;
      $display("FAIL decode_hold: got de=%0b ctrl=%0h data=%02h, required de=1 ctrl=%0h data=%02h",
               de, ctrl, data, exp_ctrl, exp_data);
    end
    check_drained("decode");
  endtask

  task automatic test_loss();
    send(TOK01, 1'b1);
    for (int i = 0; i < 31; i++) send(rand_data(), 1'b1);
    check_bit("loss_still_locked_31", locked, 1'b1);
    send(rand_data(), 1'b1);
    check_bit("loss_dropped_32", locked, 1'b0);
    exp_lock = 1'b0;
    send(rand_data(), 1'b1);
    check_bit("loss_no_out_valid", out_valid, 1'b0);
    for (int i = 0; i < 8; i++) send(TOK11, 1'b1);
    check_bit("loss_relock", locked, 1'b1);
    exp_lock = 1'b1;
    checks++;
    if (slips != 0) begin
      errors++;
      $display("FAIL loss_no_slip: got %0d slips, required 0", slips);
    end
    check_drained("loss");
  endtask

  task automatic test_slip();
    test_reset();
    for (int i = 0; i < 15; i++) send(rand_data(), 1'b1);
    check_bit("slip_not_before_16", bitslip, 1'b0);
    send(rand_data(), 1'b1);
    check_bit("slip_at_16", bitslip, 1'b1);
`ifdef TMDS_SLIP_CNT_EN
    checks++;
    if (slip_count !== 8'd1) begin
      errors++;
      $display("FAIL slip_count_1: got %0d, required 1", slip_count);
    end
`endif
    // Tokens inside the settle window must be ignored.
    for (int i = 0; i < 16; i++) send(TOK00, 1'b1);
    check_bit("slip_wait_ignored", locked, 1'b0);
    checks++;
    if (slips != 1) begin
      errors++;
      $display("FAIL slip_wait_quiet: got %0d slips, required 1", slips);
    end
    for (int i = 0; i < 15; i++) send(rand_data(), 1'b1);
    check_bit("slip2_not_before_16", bitslip, 1'b0);
    send(rand_data(), 1'b1);
    check_bit("slip2_at_16", bitslip, 1'b1);
`ifdef TMDS_SLIP_CNT_EN
    checks++;
    if (slip_count !== 8'd2) begin
      errors++;
      $display("FAIL slip_count_2: got %0d, required 2", slip_count);
    end
`endif
  endtask

  task automatic test_boundary();
    test_reset();
    for (int i = 0; i < 8; i++) send(rand_data(), 1'b1);
    for (int i = 0; i < 4; i++) send(TOK10, 1'b1);
    send(rand_data(), 1'b0);
    send(10'h155, 1'b0);
    for (int i = 0; i < 3; i++) send(TOK10, 1'b1);
    check_bit("boundary_lock_after_7", locked, 1'b0);
    send(TOK10, 1'b1);
    check_bit("boundary_locked", locked, 1'b1);
    check_bit("boundary_no_bitslip", bitslip, 1'b0);
    exp_lock = 1'b1;
    @(negedge clk);
    checks++;
    if (slips != 0) begin
      errors++;
      $display("FAIL boundary_slip_count: got %0d slips, required 0", slips);
    end
  endtask

  task automatic async_reset(input string name);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero(name);
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    async_reset("reset_while_locked");
    for (int i = 0; i < 7; i++) send(TOK00, 1'b1);
    check_bit("relock_after_7", locked, 1'b0);
    send(TOK00, 1'b1);
    check_bit("relock_after_8", locked, 1'b1);
    test_reset();
    for (int i = 0; i < 16; i++) send(rand_data(), 1'b1);
    check_bit("mid_wait_slip", bitslip, 1'b1);
    send(rand_data(), 1'b1);
    send(rand_data(), 1'b1);
    async_reset("reset_mid_slip_wait");
    for (int i = 0; i < 7; i++) send(TOK01, 1'b1);
    check_bit("post_wait_reset_7", locked, 1'b0);
    send(TOK01, 1'b1);
    check_bit("post_wait_reset_8", locked, 1'b1);
    @(negedge clk);
    checks++;
    if (slips != 0) begin
      errors++;
      $display("FAIL post_reset_no_slip: got %0d slips, required 0", slips);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_decode();
    test_loss();
    test_slip();
    test_boundary();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
